// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation is in flight at a time: IDLE (grant) -> EXEC (sample ALU) -> RESP (hold until taken).
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [4:0]        req_op0,
    input  logic [4:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [4:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count,
    output logic [1:0]        fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is only ever high in IDLE; rsp_valid is only ever high in RESP, on the winner's bit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_grant;
    logic                winner;
    logic                grant_id;
    logic                accept;
    logic                rsp_done;
    logic [4:0]          lat_op;
    logic [DATA_W-1:0]   lat_a;
    logic [DATA_W-1:0]   lat_b;

    assign alu_op_o  = lat_op;
    assign alu_a_o   = lat_a;
    assign alu_b_o   = lat_b;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        grant_id   = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // On contention the requester not served last wins.
                    grant_id            = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
                    req_ready[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_next          = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[winner] = 1'b1;
                if (rsp_ready[winner]) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            lat_op     <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                winner <= grant_id;
                lat_op <= grant_id ? req_op1 : req_op0;
                lat_a  <= grant_id ? req_a1  : req_a0;
                lat_b  <= grant_id ? req_b1  : req_b0;
            end
            if (state == EXEC) begin
                // Codes above 16 have no ALU meaning; report an error with zero data.
                if (lat_op > 5'd16) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    rsp_data <= alu_result_i;
                    rsp_err  <= 1'b0;
                end
            end
            if (rsp_done) begin
                last_grant <= winner;
                op_count   <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model on the shared ALU port.
// A second narrow-counter instance runs in lockstep to exercise counter wrap quickly.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [4:0]        req_op0, req_op1;
    logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [4:0]        alu_op_o;
    logic [DATA_W-1:0] alu_a_o, alu_b_o;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [CNT_W-1:0]  op_count;
    logic [1:0]        fsm_state;

    logic [1:0]        s_req_ready, s_rsp_valid, s_fsm_state;
    logic [4:0]        s_alu_op;
    logic [DATA_W-1:0] s_alu_a, s_alu_b, s_rsp_data;
    logic              s_rsp_err, s_busy;
    logic [2:0]        s_op_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .op_count(op_count), .fsm_state(fsm_state)
    );

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .alu_op_o(s_alu_op), .alu_a_o(s_alu_a), .alu_b_o(s_alu_b),
        .alu_result_i(alu_result), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy),
        .op_count(s_op_count), .fsm_state(s_fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, others add
    always_comb begin
        case (alu_op_o)
            5'd0:    alu_result = alu_a_o + alu_b_o;
            5'd1:    alu_result = alu_a_o - alu_b_o;
            5'd2:    alu_result = alu_a_o & alu_b_o;
            5'd3:    alu_result = alu_a_o | alu_b_o;
            5'd4:    alu_result = alu_a_o ^ alu_b_o;
            default: alu_result = alu_a_o + alu_b_o;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_op(input logic id, input logic [4:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (id) begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_valid = 2'b10;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_valid = 2'b01;
        end
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_op0 = 5'd9; req_op1 = 5'd9;
        req_a0 = 32'hDEAD; req_b0 = 32'hBEEF; req_a1 = 32'h1234; req_b1 = 32'h5678;
        do_reset();
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        n_tests++; if ({alu_op_o, alu_a_o, alu_b_o} !== '0) begin n_fail++; $display("FAIL reset_alu_regs: got %0d/%h/%h want 0/0/0", alu_op_o, alu_a_o, alu_b_o); end
        n_tests++; if (rsp_data !== '0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_data, rsp_err); end
        n_tests++; if (op_count !== '0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    endtask

    task automatic test_no_accept();
        // A request withdrawn before the edge must leave the block idle
        @(posedge clk);
        #2 req_valid = 2'b01;
        #2 req_valid = 2'b00;
        tick();
        n_tests++; if (fsm_state !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL no_accept_state: got %0d/%b want 0/0", fsm_state, busy); end
    endtask

    task automatic test_single_op();
        req_op0 = 5'd0; req_a0 = 32'd5; req_b0 = 32'd7;
        rsp_ready = 2'b01; req_valid = 2'b01;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_tests++; if (busy !== 1'b1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL single_exec: got busy %b ready %b want 1/00", busy, req_ready); end
        n_tests++; if (alu_a_o !== 32'd5 || alu_b_o !== 32'd7 || alu_op_o !== 5'd0) begin n_fail++; $display("FAIL single_alu_drive: got %0d/%0d/%0d want 0/5/7", alu_op_o, alu_a_o, alu_b_o); end
        tick();
        n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
        n_tests++; if (rsp_data !== 32'd12 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp_data: got %0d/%b want 12/0", rsp_data, rsp_err); end
        tick();
        n_tests++; if (op_count !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got count %0d busy %b want 1/0", op_count, busy); end
    endtask

    task automatic test_contention();
        logic [1:0]        exp_ready [4];
        logic [DATA_W-1:0] exp_data  [4];
        exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_data  = '{32'd17, 32'h30, 32'd17, 32'h30};
        do_reset();
        req_op0 = 5'd1; req_a0 = 32'd20;   req_b0 = 32'd3;
        req_op1 = 5'd2; req_a1 = 32'hF0;   req_b1 = 32'h3C;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (req_ready !== exp_ready[i]) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b want %b", i, req_ready, exp_ready[i]); end
            tick();
            tick();
            n_tests++; if (rsp_valid !== exp_ready[i]) begin n_fail++; $display("FAIL contention_rsp_valid[%0d]: got %b want %b", i, rsp_valid, exp_ready[i]); end
            n_tests++; if (rsp_data !== exp_data[i]) begin n_fail++; $display("FAIL contention_rsp_data[%0d]: got %h want %h", i, rsp_data, exp_data[i]); end
            tick();
        end
        req_valid = 2'b00;
        n_tests++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL contention_count: got %0d want 4", op_count); end
    endtask

    task automatic test_backpressure();
        req_op0 = 5'd3; req_a0 = 32'h0F00; req_b0 = 32'h00F0;
        req_valid = 2'b01; rsp_ready = 2'b00;
        tick();
        tick();
        // Winner is requester 0; readiness on bit 1 must be ignored
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h0FF0) begin n_fail++; $display("FAIL bp_rsp[%0d]: got %b/%h want 01/00000ff0", i, rsp_valid, rsp_data); end
            n_tests++; if (alu_op_o !== 5'd3 || alu_a_o !== 32'h0F00 || alu_b_o !== 32'h00F0) begin n_fail++; $display("FAIL bp_alu[%0d]: got %0d/%h/%h want 3/f00/f0", i, alu_op_o, alu_a_o, alu_b_o); end
            n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 00", i, req_ready); end
            tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b01;
        tick();
        n_tests++; if (fsm_state !== 2'd0 || op_count !== 16'd5) begin n_fail++; $display("FAIL bp_release: got state %0d count %0d want 0/5", fsm_state, op_count); end
    endtask

    task automatic test_illegal_op();
        req_op1 = 5'd20; req_a1 = 32'd1; req_b1 = 32'd2;
        req_valid = 2'b10; rsp_ready = 2'b10;
        #1;
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL illegal_grant: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        n_tests++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_data !== '0) begin n_fail++; $display("FAIL illegal_rsp: got %b/%b/%h want 10/1/0", rsp_valid, rsp_err, rsp_data); end
        tick();
        n_tests++; if (op_count !== 16'd6) begin n_fail++; $display("FAIL illegal_count: got %0d want 6", op_count); end
    endtask

    task automatic test_reset_in_resp();
        req_op0 = 5'd0; req_a0 = 32'd1; req_b0 = 32'd1;
        req_valid = 2'b01; rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
        n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rst_resp_pre: got %b want 01", rsp_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (fsm_state !== 2'd0 || rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_resp_state: got %0d/%b/%b want 0/00/0", fsm_state, rsp_valid, busy); end
        n_tests++; if (op_count !== '0) begin n_fail++; $display("FAIL rst_resp_count: got %0d want 0", op_count); end
        rsp_ready = 2'b01;
        tick();
        n_tests++; if (rsp_valid !== 2'b00 || op_count !== '0) begin n_fail++; $display("FAIL rst_resp_discard: got %b/%0d want 00/0", rsp_valid, op_count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) do_op(1'b0, 5'd0, i, 32'd1);
        n_tests++; if (s_op_count !== 3'd7) begin n_fail++; $display("FAIL wrap_pre: got %0d want 7", s_op_count); end
        do_op(1'b1, 5'd4, 32'hFF, 32'h0F);
        n_tests++; if (s_op_count !== 3'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", s_op_count); end
        n_tests++; if (op_count !== 16'd8 || rsp_data !== 32'hF0) begin n_fail++; $display("FAIL wrap_main: got %0d/%h want 8/f0", op_count, rsp_data); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_no_accept();
        test_single_op();
        test_contention();
        test_backpressure();
        test_illegal_op();
        test_reset_in_resp();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
